// File: rtl/fb_pkt_arbiter.sv
// Packet-level round-robin arbiter joining NUM_IN feedback-bus sources onto one stream.
// Starved ports whose pending packet waits too long are drained and dropped.
module fb_pkt_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int DW         = 32,
    parameter int DROP_AFTER = 1024
) (
    input  logic                 clk,
    input  logic                 rstf,
    input  logic [NUM_IN*DW-1:0] t_data,
    input  logic [NUM_IN-1:0]    t_valid,
    input  logic [NUM_IN-1:0]    t_last,
    output logic [NUM_IN-1:0]    t_ready,
    input  logic [NUM_IN-1:0]    port_en,
    output logic [DW-1:0]        i_data,
    output logic                 i_valid,
    output logic                 i_last,
    input  logic                 i_ready,
    output logic [NUM_IN-1:0]    grant,
    output logic [31:0]          pkt_cnt,
    output logic [31:0]          drop_cnt,
    output logic                 dbg_state_o
);

    // Handshakes: a word moves on any interface in a cycle where valid and ready
    // are both high at the clock edge; valid never waits on ready.

    localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int SW = $clog2(DROP_AFTER + 2);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PASS = 1'b1;

    localparam logic [SW-1:0] STALL_MAX = '1;
    localparam logic [SW-1:0] DROP_LIM  = SW'(DROP_AFTER);

    logic [0:0]        state_q, state_d;
    logic [IW-1:0]     g_q, g_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [SW-1:0]     stall_q [NUM_IN];
    logic [SW-1:0]     stall_d [NUM_IN];
    logic [NUM_IN-1:0] dump_q, dump_d;
    logic [31:0]       pkt_cnt_q, pkt_cnt_d;
    logic [31:0]       drop_cnt_q, drop_cnt_d;

    logic [NUM_IN-1:0] over;
    logic [NUM_IN-1:0] elig;
    logic              sel_found;
    logic [IW-1:0]     sel_idx;
    logic [IW-1:0]     cand;
    logic              pass;
    logic              out_done;
    logic              granted_p;

    // A port already past the threshold is kept out of the search so the dump wins.
    always_comb begin
        over = '0;
        for (int p = 0; p < NUM_IN; p++) begin
            over[p] = stall_q[p] > DROP_LIM;
        end
        elig = t_valid & port_en & ~dump_q & ~over;
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_IN; i++) begin
            cand = IW'((int'(rr_q) + i) % NUM_IN);
            if (!sel_found && elig[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        pass     = rstf && (state_q == S_PASS);
        i_data   = pass ? t_data[int'(g_q)*DW +: DW] : '0;
        i_valid  = pass && t_valid[g_q];
        i_last   = pass && t_last[g_q];
        grant    = pass ? (NUM_IN'(1) << g_q) : '0;
        out_done = i_valid && i_ready && i_last;
        t_ready  = '0;
        for (int p = 0; p < NUM_IN; p++) begin
            t_ready[p] = rstf && (dump_q[p] || (state_q == S_PASS && g_q == IW'(p) && i_ready));
        end
        pkt_cnt     = rstf ? pkt_cnt_q : '0;
        drop_cnt    = rstf ? drop_cnt_q : '0;
        dbg_state_o = rstf && (state_q == S_PASS);
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        rr_d      = rr_q;
        pkt_cnt_d = pkt_cnt_q + 32'(out_done);
        if (state_q == S_IDLE) begin
            if (sel_found) begin
                state_d = S_PASS;
                g_d     = sel_idx;
            end
        end else if (out_done) begin
            state_d = S_IDLE;
            rr_d    = g_q;
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        dump_d     = dump_q;
        granted_p  = 1'b0;
        for (int p = 0; p < NUM_IN; p++) begin
            stall_d[p] = stall_q[p];
            granted_p  = (state_q == S_PASS && g_q == IW'(p)) ||
                         (state_q == S_IDLE && sel_found && sel_idx == IW'(p));
            if (dump_q[p]) begin
                if (t_valid[p] && t_last[p]) begin
                    dump_d[p]  = 1'b0;
                    stall_d[p] = '0;
                    drop_cnt_d = drop_cnt_d + 32'd1;
                end
            end else if (!port_en[p] || granted_p) begin
                stall_d[p] = '0;
            end else if (over[p]) begin
                dump_d[p] = 1'b1;
            end else if (t_valid[p] && state_q == S_PASS && stall_q[p] != STALL_MAX) begin
                stall_d[p] = stall_q[p] + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstf) begin
            state_q    <= S_IDLE;
            g_q        <= '0;
            rr_q       <= IW'(NUM_IN - 1);
            dump_q     <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            for (int p = 0; p < NUM_IN; p++) begin
                stall_q[p] <= '0;
            end
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            rr_q       <= rr_d;
            dump_q     <= dump_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            stall_q    <= stall_d;
        end
    end

endmodule

// File: doc/fb_pkt_arbiter.md
# fb_pkt_arbiter

Packet-level round-robin arbiter that shares one feedback-bus output stream among NUM_IN upstream feedback-bus sources (mapmov/PC path, EQ loops, etc.). It grants one source at a time and holds the grant from the first word to the t_last word. A starved source whose pending packet has been blocked too long is drained and discarded, so no requester can wedge the bus. It sits in front of the feedback-bus consumer and generalises the two-way join to N requesters with per-port enables and status counters.

## Interface
- NUM_IN, 4: number of requesting ports (2..8).
- DW, 32: data width per port.
- DROP_AFTER, 1024: blocked-cycle threshold; a port is dumped when its stall count exceeds this value.
- clk  in  1  system clock.
- rstf  in  1  reset; one clock, reset is synchronous and active-low.
- t_data  in  NUM_IN*DW  port p occupies bits [p*DW +: DW].
- t_valid  in  NUM_IN  per-port valid.
- t_last  in  NUM_IN  per-port end of packet.
- t_ready  out  NUM_IN  per-port ready.
- port_en  in  NUM_IN  per-port enable (config, quasi-static).
- i_data  out  DW  arbitrated data.
- i_valid  out  1  arbitrated valid.
- i_last  out  1  arbitrated last.
- i_ready  in  1  downstream ready.
- grant  out  NUM_IN  one-hot current grant; 0 when idle.
- pkt_cnt  out  32  packets forwarded (last handshakes on output).
- drop_cnt  out  32  packets discarded by dump.

## Operation
- States: IDLE, PASS. One grant register g and one last-served pointer rr.
- IDLE:
  - i_valid, i_last, i_data and grant are 0.
  - t_ready is 0 except for dumping ports.
  - Eligible port: t_valid=1, port_en=1, not dumping.
  - If any port is eligible, select the first eligible port searching from rr+1 upward, modulo NUM_IN. Register g and go to PASS.
- PASS:
  - i_data, i_valid and i_last mux combinationally from port g.
  - t_ready[g] = i_ready. Every other port's t_ready is 0 unless that port is dumping.
  - On i_valid & i_ready & i_last: increment pkt_cnt, set rr = g, go to IDLE.
  - The packet always completes. port_en[g] falling mid-packet has no effect until the last word.
- Stall counter, per port p:
  - Increments each cycle that t_valid[p] & port_en[p] & not dumping & state=PASS & g≠p.
  - Clears when p is granted, or when port_en[p]=0.
  - Holds otherwise. Saturates at all-ones.
- Dump, per port p:
  - Entered the cycle after stall_cnt[p] > DROP_AFTER.
  - While dumping, t_ready[p]=1; words are consumed and discarded.
  - Dump ends on the cycle t_valid[p] & t_last[p] is accepted. In that same cycle: drop_cnt++, stall_cnt[p] clears, dump flag clears.
  - p is eligible for grant no earlier than the following cycle.
  - Dumping takes precedence over grant for that port.
  - Several ports may dump simultaneously. drop_cnt adds the number of ports completing a dump in that cycle.
- Counters wrap modulo 2^32.

## Timing
- Reset values: state=IDLE, g=0, rr=NUM_IN-1 (so port 0 is searched first), all stall counters and dump flags 0, pkt_cnt=0, drop_cnt=0.
- Outputs during reset: all outputs 0.
- Grant latency: an eligible t_valid seen in IDLE at cycle n gives grant/i_valid at n+1. The first word can handshake at n+1.
- Packet gap: one IDLE bubble cycle between consecutive packets, including the same port back-to-back.
- Datapath: zero-latency combinational passthrough in PASS. No buffering, no data reordering, AXI-stream-style valid/ready rules.
- Dump start: stall_cnt reaching DROP_AFTER+1 at cycle m asserts t_ready[p] at m+1.
- Reset mid-packet: the block returns to IDLE next cycle with all state cleared. The upstream remainder of a packet is then arbitrated as a new packet. The system resets sources together.

## Test plan
- Single port: port 0 sends a 4-word packet (0xA0..0xA3, last on 0xA3), i_ready=1 -> grant=0001 one cycle after valid, 4 output words in order, pkt_cnt=1, IDLE after the last word.
- Round robin: all 4 ports hold 2-word packets, i_ready=1 -> output order ports 0,1,2,3,0, one idle cycle between packets, pkt_cnt=5 after the fifth packet.
- Backpressure: port 2 sends 6 words while i_ready toggles 1,0,0,1,… -> t_ready[2] mirrors i_ready exactly, all 6 words appear unmodified, no duplicates.
- Starvation drop: DROP_AFTER=8; port 0 sends a 100-word packet, and port 1 raises valid with a 5-word packet 1 cycle after port 0 is granted -> t_ready[1]=1 after 9 blocked cycles, port 1's 5 words consumed, none appear on i_data, drop_cnt=1, port 0's packet intact.
- Enable mask: port_en=1101, ports 1 and 3 valid -> only port 3 granted, port 1 t_ready stays 0, its stall_cnt stays 0 and no dump occurs. Clearing port_en[3] mid-packet still completes port 3's packet.
- Reset mid-packet: rstf low for 1 cycle during word 2 of a port-0 packet -> next cycle grant=0, i_valid=0, pkt_cnt=0, drop_cnt=0. The remaining port-0 words are then granted as a new packet.
